// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI4 slave memory with independent single-outstanding write and read engines
module axi_slave_mem #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int ID_W     = 4,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 0
) (
    input  logic                  aclk,
    input  logic                  arst,
    input  logic [ID_W-1:0]       awid,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [7:0]            awlen,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_W-1:0]       arid,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [7:0]            arlen,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_W-1:0]       rid,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int WA_W   = ADDR_W - OFF_W;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic oor(input logic [WA_W-1:0] a);
        return 32'(a) >= 32'(DEPTH);
    endfunction

    // Illegal bursts fall back to INCR, so only FIXED and legal WRAP need flags.
    function automatic logic [WA_W-1:0] nxt(input logic [WA_W-1:0] a, input logic fix,
                                            input logic wrap, input logic [7:0] len);
        logic [WA_W-1:0] m;
        logic [WA_W-1:0] inc;
        m   = WA_W'(len);
        inc = a + 1'b1;
        if (fix)  return a;
        if (wrap) return (a & ~m) | (inc & m);
        return inc;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};

    // ---------------- write engine ----------------
    w_state_t          w_state_q, w_state_d;
    logic [WA_W-1:0]   waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic              wfix_q, wfix_d, wwrap_q, wwrap_d, werr_q, werr_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic              aw_hs, w_hs, b_hs, w_last_beat;

    always_comb begin
        w_state_d   = w_state_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wbeat_d     = wbeat_q;
        wfix_d      = wfix_q;
        wwrap_d     = wwrap_q;
        werr_d      = werr_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        aw_hs       = awvalid && awready_q;
        w_hs        = wvalid && wready_q;
        b_hs        = bvalid_q && bready;
        w_last_beat = (wbeat_q == wlen_q);
        case (w_state_q)
            W_IDLE: if (aw_hs) begin
                w_state_d = W_DATA;
                waddr_d   = awaddr[ADDR_W-1:OFF_W];
                wlen_d    = awlen;
                wbeat_d   = 8'd0;
                wfix_d    = (awburst == 2'b00);
                wwrap_d   = (awburst == 2'b10) && wrap_len_ok(awlen);
                werr_d    = (awburst == 2'b11) || ((awburst == 2'b10) && !wrap_len_ok(awlen));
                bid_d     = awid;
            end
            W_DATA: if (w_hs) begin
                waddr_d = nxt(waddr_q, wfix_q, wwrap_q, wlen_q);
                wbeat_d = wbeat_q + 8'd1;
                // The beat counter decides completion; wlast only feeds the error flag.
                werr_d  = werr_q || oor(waddr_q) || (wlast != w_last_beat);
                if (w_last_beat) begin
                    w_state_d = W_RESP;
                    bresp_d   = werr_d ? 2'b10 : 2'b00;
                end
            end
            W_RESP: if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            wfix_q    <= 1'b0;
            wwrap_q   <= 1'b0;
            werr_q    <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
            wfix_q    <= wfix_d;
            wwrap_q   <= wwrap_d;
            werr_q    <= werr_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && !oor(waddr_q)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[waddr_q[IDX_W-1:0]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_t          r_state_q, r_state_d;
    logic [WA_W-1:0]   raddr_q, raddr_d;
    logic [7:0]        rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic              rfix_q, rfix_d, rwrap_q, rwrap_d, rerr_q, rerr_d;
    logic [3:0]        lat_q, lat_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d, arready_q, arready_d, rvalid_q, rvalid_d;
    logic              ar_hs, r_hs, r_load;
    logic [WA_W-1:0]   ld_addr;
    logic [7:0]        ld_len, ld_beat;
    logic              ld_fix, ld_wrap, ld_err;

    // With READ_LAT=0 the first beat loads straight from the AR channel.
    always_comb begin
        if (r_state_q == R_IDLE) begin
            ld_addr = araddr[ADDR_W-1:OFF_W];
            ld_len  = arlen;
            ld_beat = 8'd0;
            ld_fix  = (arburst == 2'b00);
            ld_wrap = (arburst == 2'b10) && wrap_len_ok(arlen);
            ld_err  = (arburst == 2'b11) || ((arburst == 2'b10) && !wrap_len_ok(arlen));
        end else begin
            ld_addr = raddr_q;
            ld_len  = rlen_q;
            ld_beat = rbeat_q;
            ld_fix  = rfix_q;
            ld_wrap = rwrap_q;
            ld_err  = rerr_q;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        rfix_d    = rfix_q;
        rwrap_d   = rwrap_q;
        rerr_d    = rerr_q;
        lat_d     = lat_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        r_load    = 1'b0;
        ar_hs     = arvalid && arready_q;
        r_hs      = rvalid_q && rready;
        case (r_state_q)
            R_IDLE: if (ar_hs) begin
                raddr_d = ld_addr;
                rlen_d  = ld_len;
                rbeat_d = 8'd0;
                rfix_d  = ld_fix;
                rwrap_d = ld_wrap;
                rerr_d  = ld_err;
                rid_d   = arid;
                if (READ_LAT == 0) begin
                    r_state_d = R_DATA;
                    r_load    = 1'b1;
                end else begin
                    r_state_d = R_WAIT;
                    lat_d     = 4'(READ_LAT - 1);
                end
            end
            R_WAIT: if (lat_q == 4'd0) begin
                r_state_d = R_DATA;
                r_load    = 1'b1;
            end else begin
                lat_d = lat_q - 4'd1;
            end
            R_DATA: if (r_hs) begin
                if (rlast_q) r_state_d = R_IDLE;
                else         r_load    = 1'b1;
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_load) begin
            rresp_d = (ld_err || oor(ld_addr)) ? 2'b10 : 2'b00;
            rlast_d = (ld_beat == ld_len);
            raddr_d = nxt(ld_addr, ld_fix, ld_wrap, ld_len);
            rbeat_d = ld_beat + 8'd1;
        end
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rfix_q    <= 1'b0;
            rwrap_q   <= 1'b0;
            rerr_q    <= 1'b0;
            lat_q     <= '0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
            rfix_q    <= rfix_d;
            rwrap_q   <= rwrap_d;
            rerr_q    <= rerr_d;
            lat_q     <= lat_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            if (r_load) rdata_q <= oor(ld_addr) ? '0 : mem[ld_addr[IDX_W-1:0]];
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign bvalid  = bvalid_q;
    assign arready = arready_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - directed self-checking bench for axi_slave_mem
module tb_axi_slave_mem;

    localparam int LIM = 200;

    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic [3:0]  awid = '0, arid = '0, bid, rid;
    logic [15:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rlast, rvalid;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];
    logic [1:0]  rrbuf [16];
    logic        rlbuf [16];
    logic [3:0]  ridbuf [16];
    logic [1:0]  bresp_got;
    logic [3:0]  bid_got;
    int          first_k;

    axi_slave_mem #(.DATA_W(32), .ADDR_W(16), .ID_W(4), .DEPTH(1024), .READ_LAT(3)) dut (
        .aclk(aclk), .arst(arst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                      input logic [3:0] id, input logic [3:0] strb, input int last_at, input int bdelay);
        int n;
        awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1'b1; n = 0;
        while (!awready && n < LIM) begin @(negedge aclk); n++; end
        if (n >= LIM) check("aw_timeout", 1, 0);
        @(negedge aclk); awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i]; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1; n = 0;
            while (!wready && n < LIM) begin @(negedge aclk); n++; end
            if (n >= LIM) check("w_timeout", 1, 0);
            if (i == int'(len)) check("b_early", bvalid, 0);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0; n = 0;
        while (!bvalid && n < LIM) begin @(negedge aclk); n++; end
        if (n >= LIM) check("b_timeout", 1, 0);
        repeat (bdelay) @(negedge aclk);
        if (bdelay > 0) check("b_hold", bvalid, 1);
        bid_got = bid; bresp_got = bresp; bready = 1'b1;
        @(negedge aclk); bready = 1'b0;
        check("b_drop", bvalid, 0);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                      input logic [3:0] id, input logic [3:0] pat);
        int n, j, got;
        logic [31:0] held;
        logic stalled;
        araddr = addr; arlen = len; arburst = burst; arid = id; arvalid = 1'b1; n = 0;
        while (!arready && n < LIM) begin @(negedge aclk); n++; end
        if (n >= LIM) check("ar_timeout", 1, 0);
        @(negedge aclk); arvalid = 1'b0; first_k = 1;
        while (!rvalid && first_k < LIM) begin @(negedge aclk); first_k++; end
        got = 0; j = 0; stalled = 1'b0; n = 0; held = '0;
        while (got <= int'(len) && n < LIM) begin
            if (rvalid) begin
                if (stalled) check("r_stable", rdata, held);
                rready = pat[j % 4]; j++;
                if (rready) begin
                    rbuf[got] = rdata; rrbuf[got] = rresp; rlbuf[got] = rlast; ridbuf[got] = rid;
                    got++; stalled = 1'b0;
                end else begin
                    held = rdata; stalled = 1'b1;
                end
            end else begin
                rready = 1'b0;
            end
            @(negedge aclk); n++;
        end
        rready = 1'b0;
        if (got <= int'(len)) check("r_timeout", got, len + 1);
        check("r_done", rvalid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge aclk);
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        arst = 1'b0;
        @(negedge aclk);
        check("post_rst_awready", awready, 1);
        check("post_rst_arready", arready, 1);

        // INCR write then read back, B held under back-pressure
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        wr(16'h0010, 8'd3, 2'b01, 4'd5, 4'hF, 3, 2);
        check("incr_bresp", bresp_got, 2'b00);
        check("incr_bid", bid_got, 4'd5);
        rd(16'h0010, 8'd3, 2'b01, 4'd9, 4'b1111);
        check("incr_lat", first_k, 4);
        for (int i = 0; i < 4; i++) begin
            check("incr_rdata", rbuf[i], 32'hA0 + i);
            check("incr_rresp", rrbuf[i], 2'b00);
            check("incr_rlast", rlbuf[i], i == 3);
            check("incr_rid", ridbuf[i], 4'd9);
        end

        // WRAP from word 6 over a 4-word block: 6,7,4,5
        rd(16'h0018, 8'd3, 2'b10, 4'd2, 4'b1111);
        check("wrap_d0", rbuf[0], 32'hA2);
        check("wrap_d1", rbuf[1], 32'hA3);
        check("wrap_d2", rbuf[2], 32'hA0);
        check("wrap_d3", rbuf[3], 32'hA1);
        for (int i = 0; i < 4; i++) check("wrap_rresp", rrbuf[i], 2'b00);

        // FIXED write: every beat lands on word 8
        wbuf[0] = 32'hB0; wbuf[1] = 32'hB1; wbuf[2] = 32'hB2;
        wr(16'h0020, 8'd2, 2'b00, 4'd1, 4'hF, 2, 0);
        check("fixed_bresp", bresp_got, 2'b00);
        rd(16'h0020, 8'd0, 2'b01, 4'd1, 4'b1111);
        check("fixed_rdata", rbuf[0], 32'hB2);

        // WRAP with illegal len 2: SLVERR, walks as INCR 6,7,8
        rd(16'h0018, 8'd2, 2'b10, 4'd3, 4'b1111);
        check("badwrap_d0", rbuf[0], 32'hA2);
        check("badwrap_d1", rbuf[1], 32'hA3);
        check("badwrap_d2", rbuf[2], 32'hB2);
        for (int i = 0; i < 3; i++) check("badwrap_rresp", rrbuf[i], 2'b10);
        check("badwrap_rlast", rlbuf[2], 1);

        // byte strobes
        wbuf[0] = 32'hFFFF_FFFF;
        wr(16'h0000, 8'd0, 2'b01, 4'd2, 4'hF, 0, 0);
        wbuf[0] = 32'h1234_5678;
        wr(16'h0000, 8'd0, 2'b01, 4'd3, 4'b0101, 0, 0);
        rd(16'h0000, 8'd0, 2'b01, 4'd4, 4'b1111);
        check("strb_rdata", rbuf[0], 32'hFF34_FF78);
        check("strb_rlast", rlbuf[0], 1);

        // read back-pressure pattern 1,0,0,1
        rd(16'h0010, 8'd3, 2'b01, 4'd7, 4'b1001);
        check("bp_lat", first_k, 4);
        for (int i = 0; i < 4; i++) begin
            check("bp_rdata", rbuf[i], 32'hA0 + i);
            check("bp_rlast", rlbuf[i], i == 3);
        end
        check("bp_rid", ridbuf[3], 4'd7);

        // out of range accesses at DEPTH*4
        rd(16'h1000, 8'd0, 2'b01, 4'd8, 4'b1111);
        check("oor_rdata", rbuf[0], 32'h0);
        check("oor_rresp", rrbuf[0], 2'b10);
        wbuf[0] = 32'hDEAD_BEEF;
        wr(16'h1000, 8'd0, 2'b01, 4'd8, 4'hF, 0, 0);
        check("oor_bresp", bresp_got, 2'b10);
        rd(16'h0000, 8'd0, 2'b01, 4'd8, 4'b1111);
        check("oor_no_alias", rbuf[0], 32'hFF34_FF78);

        // wlast early, wlast missing, reserved burst type
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0 + i;
        wr(16'h0040, 8'd3, 2'b01, 4'd6, 4'hF, 1, 0);
        check("early_wlast_bresp", bresp_got, 2'b10);
        check("early_wlast_bid", bid_got, 4'd6);
        wr(16'h0060, 8'd1, 2'b01, 4'd6, 4'hF, 99, 0);
        check("no_wlast_bresp", bresp_got, 2'b10);
        wbuf[0] = 32'hE0; wbuf[1] = 32'hE1;
        wr(16'h0070, 8'd1, 2'b11, 4'd10, 4'hF, 1, 0);
        check("rsvd_bresp", bresp_got, 2'b10);
        rd(16'h0070, 8'd1, 2'b01, 4'd10, 4'b1111);
        check("rsvd_d0", rbuf[0], 32'hE0);
        check("rsvd_d1", rbuf[1], 32'hE1);

        // reset in the middle of a write burst
        awaddr = 16'h0080; awlen = 8'd3; awburst = 2'b01; awid = 4'd4; awvalid = 1'b1; n = 0;
        while (!awready && n < LIM) begin @(negedge aclk); n++; end
        if (n >= LIM) check("mid_aw_timeout", 1, 0);
        @(negedge aclk); awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = 32'h55 + i; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1; n = 0;
            while (!wready && n < LIM) begin @(negedge aclk); n++; end
            if (n >= LIM) check("mid_w_timeout", 1, 0);
            @(negedge aclk);
        end
        arst = 1'b1;
        #1;
        check("mid_rst_wready", wready, 0);
        check("mid_rst_bvalid", bvalid, 0);
        wvalid = 1'b0;
        @(negedge aclk); arst = 1'b0;
        @(negedge aclk);
        check("mid_post_awready", awready, 1);
        check("mid_post_bvalid", bvalid, 0);
        wbuf[0] = 32'h77; wbuf[1] = 32'h78;
        wr(16'h0080, 8'd1, 2'b01, 4'd11, 4'hF, 1, 0);
        check("mid_new_bresp", bresp_got, 2'b00);
        check("mid_new_bid", bid_got, 4'd11);
        rd(16'h0080, 8'd1, 2'b01, 4'd12, 4'b1111);
        check("mid_new_d0", rbuf[0], 32'h77);
        check("mid_new_d1", rbuf[1], 32'h78);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem
Overview:
- Synthesizable, parametrised AXI4 slave memory; successor to the behavioural slave BFM. Sits on the axi_intf in place of a DUT so master BFM/monitor/coverage run against real RTL.
- Independent write and read engines, one outstanding transaction each; FIXED/INCR/WRAP bursts, byte strobes, programmable read latency, SLVERR on illegal accesses.
Parameters:
- DATA_W, 32, data width in bits (32 or 64); every beat is full width, so AxSIZE is not ported.
- ADDR_W, 16, byte-address width.
- ID_W, 4, transaction ID width.
- DEPTH, 1024, memory words of DATA_W. READ_LAT, 0, extra idle cycles before the first R beat (0..15).
Ports:
aclk  in  1  clock; all logic on posedge
arst  in  1  reset, asynchronous, active-high
awid  in  ID_W  write ID
awaddr  in  ADDR_W  write start byte address
awlen  in  8  beats-1
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_W  echoed awid
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  B valid
bready  in  1  B ready
arid  in  ID_W  read ID
araddr  in  ADDR_W  read start byte address
arlen  in  8  beats-1
arburst  in  2  burst type, as awburst
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_W  echoed arid
rdata  out  DATA_W  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R ready
Behaviour:
- Reset (async): all outputs 0; both FSMs to IDLE; memory contents not reset. Reset mid-burst aborts the burst, with no B/R response. awready and arready go to 1 on the first clock after arst deasserts.
- Word index = byte address >> log2(DATA_W/8). Low address bits are ignored, so beats are aligned. Index >= DEPTH is out of range: the beat's write is dropped, its read returns 0, and the response is SLVERR (sticky for the burst on B; per beat on R).
- Next address:
  - FIXED: unchanged.
  - INCR: +1 word; wraps modulo 2^ADDR_W.
  - WRAP: wraps within a (len+1)-word aligned block. len must be 1, 3, 7 or 15, otherwise the whole burst is SLVERR and handled as INCR.
  - Burst type 11: SLVERR, handled as INCR.
- Write FSM:
  - W_IDLE (awready=1): on AW handshake, latch id, addr, len and burst, then go to W_DATA.
  - W_DATA (wready=1, awready=0): each W handshake writes the bytes selected by wstrb, then advances the address and beat counter. The handshake on beat len goes to W_RESP.
  - A wlast asserted early, or missing on beat len, gives SLVERR; beat counting is authoritative.
  - W_RESP (bvalid=1, bid, bresp held stable): on bready go to W_IDLE. B is never issued before the last W handshake.
- Read FSM:
  - R_IDLE (arready=1): on AR handshake, latch fields and go to R_WAIT for READ_LAT cycles, then R_DATA.
  - With READ_LAT=0, rvalid is 1 on the cycle after the AR handshake.
  - R_DATA: rdata, rresp, rid and rlast are registered and held stable while rvalid && !rready. Each handshake loads the next beat.
  - rlast=1 exactly on beat len. The handshake of that beat goes to R_IDLE, with rvalid=0 on the next cycle.
- Read and write run concurrently. A read beat loaded in the same cycle as a write to the same word returns the pre-write data.
Test Plan:
- INCR write: awaddr=0x10, awlen=3, wdata 0xA0..0xA3, wstrb=F, then INCR read of the same range -> bresp=00; R returns 0xA0..0xA3, rlast only on the 4th beat, rid=arid.
- WRAP read: araddr=0x18, arlen=3, 32-bit data -> word order 6,7,4,5, all rresp=00. Repeat with arlen=2 -> 3 beats, all SLVERR.
- Strobes: write 0xFFFFFFFF to word 0, then 0x12345678 with wstrb=0101 -> read returns 0xFF34FF78.
- Back-pressure: rready toggled 1,0,0,1, READ_LAT=3 -> first rvalid 4 cycles after AR; rdata stable while stalled; bvalid held until bready, with bid correct.
- Errors: address DEPTH*4 -> SLVERR with read data 0; wlast on beat 1 of awlen=3 -> bresp=10.
- arst pulsed mid write burst -> bvalid=0, awready=1 after reset, and a new burst completes normally.
